acq_peak_search: RTL and testbench

Collects per-Doppler-bin peak results from the acquisition magnitude/peak stage and keeps the strongest and second-strongest bin maxima over one Doppler sweep. At the end of the sweep it makes a threshold and margin detection decision. It then presents one acquisition result through a valid/ready handshake to the tracking-handover logic. It sits directly downstream of the per-bin magnitude/max stage in the AXIS acquisition chain.

---
 rtl/acq_peak_search_pkg.sv | 22 ++
 rtl/acq_peak_search_top2_tracker.sv | 59 +++++
 rtl/acq_peak_search.sv | 155 +++++++++++++++
 tb/tb_acq_peak_search.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_peak_search_pkg.sv
// Shared types and default widths for the acquisition peak-search stage.
package acq_peak_search_pkg;

  localparam int DSIZE_DIV2 = 16;
  localparam int BIN_W      = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DECIDE,
    ST_REPORT
  } acq_state_e;

  typedef struct packed {
    logic                  detected;
    logic [DSIZE_DIV2-1:0] peak;
    logic [DSIZE_DIV2-1:0] code_phase;
    logic [BIN_W-1:0]      doppler_bin;
    logic [DSIZE_DIV2-1:0] second;
  } acq_result_t;

endpackage

// File: rtl/acq_peak_search_top2_tracker.sv
// Keeps the largest and second-largest values seen since the last clear,
// plus the index and bin of the largest one.
module acq_top2_tracker #(
  parameter int DATA_W = 16,
  parameter int BIN_W  = 6
) (
  input  logic              clk,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] value,
  input  logic [DATA_W-1:0] index,
  input  logic [BIN_W-1:0]  bin,
  output logic [DATA_W-1:0] best,
  output logic [DATA_W-1:0] second,
  output logic [DATA_W-1:0] best_index,
  output logic [BIN_W-1:0]  best_bin
);

  logic [DATA_W-1:0] best_q, best_d;
  logic [DATA_W-1:0] second_q, second_d;
  logic [DATA_W-1:0] index_q, index_d;
  logic [BIN_W-1:0]  bin_q, bin_d;

  // Strict compares: an equal value never displaces the earlier best.
  always_comb begin
    best_d   = best_q;
    second_d = second_q;
    index_d  = index_q;
    bin_d    = bin_q;
    if (clr) begin
      best_d   = '0;
      second_d = '0;
      index_d  = '0;
      bin_d    = '0;
    end else if (en) begin
      if (value > best_q) begin
        second_d = best_q;
        best_d   = value;
        index_d  = index;
        bin_d    = bin;
      end else if (value > second_q) begin
        second_d = value;
      end
    end
  end

  always_ff @(posedge clk) begin
    best_q   <= best_d;
    second_q <= second_d;
    index_q  <= index_d;
    bin_q    <= bin_d;
  end

  assign best       = best_q;
  assign second     = second_q;
  assign best_index = index_q;
  assign best_bin   = bin_q;

endmodule

// File: rtl/acq_peak_search.sv
// Tracks the two strongest Doppler-bin peaks over one sweep, makes the
// threshold/margin decision and hands one result to tracking via valid/ready.
module acq_peak_search
  import acq_peak_search_pkg::*;
(
  input  logic                  s00_axis_aclk,
  input  logic                  s00_axis_areset,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_num_bins,
  input  logic [DSIZE_DIV2-1:0] i_threshold,
  input  logic [DSIZE_DIV2-1:0] i_margin,
  input  logic [DSIZE_DIV2-1:0] i_max,
  input  logic [DSIZE_DIV2-1:0] i_max_index,
  input  logic                  i_done,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_detected,
  output logic [DSIZE_DIV2-1:0] o_peak,
  output logic [DSIZE_DIV2-1:0] o_code_phase,
  output logic [BIN_W-1:0]      o_doppler_bin,
  output logic [DSIZE_DIV2-1:0] o_second,
  output logic                  o_busy,
  output logic                  o_overrun
);

  acq_state_e            state_q, state_d;
  logic [BIN_W-1:0]      num_bins_q, num_bins_d;
  logic [BIN_W-1:0]      bin_cnt_q, bin_cnt_d;
  logic [DSIZE_DIV2-1:0] thr_q, thr_d;
  logic [DSIZE_DIV2-1:0] margin_q, margin_d;
  acq_result_t           result_q, result_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  overrun_q, overrun_d;

  logic                  trk_en, trk_clr;
  logic [DSIZE_DIV2-1:0] trk_best, trk_second, trk_index;
  logic [BIN_W-1:0]      trk_bin;

  // Difference is taken one bit wider so it can never wrap.
  function automatic logic detect_fn(input logic [DSIZE_DIV2-1:0] best,
                                     input logic [DSIZE_DIV2-1:0] second,
                                     input logic [DSIZE_DIV2-1:0] thr,
                                     input logic [DSIZE_DIV2-1:0] margin);
    logic [DSIZE_DIV2:0] diff;
    diff = {1'b0, best} - {1'b0, second};
    return (best >= thr) && (diff >= {1'b0, margin});
  endfunction

  acq_top2_tracker #(
    .DATA_W(DSIZE_DIV2),
    .BIN_W (BIN_W)
  ) u_top2 (
    .clk       (s00_axis_aclk),
    .en        (trk_en),
    .clr       (trk_clr),
    .value     (i_max),
    .index     (i_max_index),
    .bin       (bin_cnt_q),
    .best      (trk_best),
    .second    (trk_second),
    .best_index(trk_index),
    .best_bin  (trk_bin)
  );

  always_comb begin
    state_d    = state_q;
    num_bins_d = num_bins_q;
    bin_cnt_d  = bin_cnt_q;
    thr_d      = thr_q;
    margin_d   = margin_q;
    result_d   = result_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    trk_en     = 1'b0;
    trk_clr    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d    = ST_COLLECT;
          num_bins_d = (i_num_bins == '0) ? BIN_W'(1) : i_num_bins;
          thr_d      = i_threshold;
          margin_d   = i_margin;
          bin_cnt_d  = '0;
          overrun_d  = 1'b0;
          trk_clr    = 1'b1;
        end
      end
      ST_COLLECT: begin
        if (i_done) begin
          trk_en    = 1'b1;
          bin_cnt_d = bin_cnt_q + BIN_W'(1);
          if (bin_cnt_q == num_bins_q - BIN_W'(1)) state_d = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        result_d.detected    = detect_fn(trk_best, trk_second, thr_q, margin_q);
        result_d.peak        = trk_best;
        result_d.code_phase  = trk_index;
        result_d.doppler_bin = trk_bin;
        result_d.second      = trk_second;
        valid_d              = 1'b1;
        state_d              = ST_REPORT;
      end
      ST_REPORT: begin
        if (valid_q && i_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A bin result outside COLLECT has nowhere to go; flag it.
    if (i_done && (state_q != ST_COLLECT)) overrun_d = 1'b1;

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state_q    <= ST_IDLE;
      num_bins_q <= BIN_W'(1);
      bin_cnt_q  <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_bins_q <= num_bins_d;
      bin_cnt_q  <= bin_cnt_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    thr_q    <= thr_d;
    margin_q <= margin_d;
  end

  assign o_valid       = valid_q;
  assign o_busy        = busy_q;
  assign o_overrun     = overrun_q;
  assign o_detected    = result_q.detected;
  assign o_peak        = result_q.peak;
  assign o_code_phase  = result_q.code_phase;
  assign o_doppler_bin = result_q.doppler_bin;
  assign o_second      = result_q.second;

endmodule

// File: tb/tb_acq_peak_search.sv
// Randomized and directed bench for acq_peak_search against a sort-based model.
module tb_acq_peak_search;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [5:0]  i_num_bins = '0;
  logic [15:0] i_threshold = '0;
  logic [15:0] i_margin = '0;
  logic [15:0] i_max = '0;
  logic [15:0] i_max_index = '0;
  logic        i_done = 1'b0;
  logic        i_ready = 1'b0;
  logic        o_valid, o_detected, o_busy, o_overrun;
  logic [15:0] o_peak, o_code_phase, o_second;
  logic [5:0]  o_doppler_bin;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mx [64];
  logic [15:0] ix [64];

  always #5 clk = ~clk;

  acq_peak_search dut (
    .s00_axis_aclk  (clk),
    .s00_axis_areset(rst),
    .i_start        (i_start),
    .i_num_bins     (i_num_bins),
    .i_threshold    (i_threshold),
    .i_margin       (i_margin),
    .i_max          (i_max),
    .i_max_index    (i_max_index),
    .i_done         (i_done),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_detected     (o_detected),
    .o_peak         (o_peak),
    .o_code_phase   (o_code_phase),
    .o_doppler_bin  (o_doppler_bin),
    .o_second       (o_second),
    .o_busy         (o_busy),
    .o_overrun      (o_overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Best = largest value (earliest on ties), second = next entry of the
  // descending-sorted list, decision from plain integer arithmetic.
  task automatic model(input int n, input int thr, input int mar,
                       output int best, output int second, output int bidx,
                       output int bbin, output int det);
    int s[$];
    for (int k = 0; k < n; k++) s.push_back(int'(mx[k]));
    s.rsort();
    best   = s[0];
    second = (n > 1) ? s[1] : 0;
    bidx   = 0;
    bbin   = 0;
    if (best != 0) begin
      for (int k = n - 1; k >= 0; k--)
        if (int'(mx[k]) == best) begin
          bidx = int'(ix[k]);
          bbin = k;
        end
    end
    det = ((best >= thr) && ((best - second) >= mar)) ? 1 : 0;
  endtask

  task automatic check_result(input string pfx, input int det, input int best,
                              input int bidx, input int bbin, input int second);
    check_eq({pfx, "_det"}, 32'(o_detected), 32'(det));
    check_eq({pfx, "_peak"}, 32'(o_peak), 32'(best));
    check_eq({pfx, "_idx"}, 32'(o_code_phase), 32'(bidx));
    check_eq({pfx, "_bin"}, 32'(o_doppler_bin), 32'(bbin));
    check_eq({pfx, "_second"}, 32'(o_second), 32'(second));
  endtask

  task automatic run_sweep(input int nb_cfg, input int thr, input int mar, input int hold,
                           input bit inj_report, input bit start_mid, input bit start_with_done);
    int eff, best, second, bidx, bbin, det, gap;
    bit exp_ovr;
    eff = (nb_cfg == 0) ? 1 : nb_cfg;
    model(eff, thr, mar, best, second, bidx, bbin, det);

    i_num_bins  = 6'(nb_cfg);
    i_threshold = 16'(thr);
    i_margin    = 16'(mar);
    i_start     = 1'b1;
    if (start_with_done) begin
      i_done      = 1'b1;
      i_max       = 16'hFFFF;
      i_max_index = 16'hAAAA;
    end
    tick;
    i_start     = 1'b0;
    i_done      = 1'b0;
    i_num_bins  = 6'($urandom);
    i_threshold = 16'($urandom);
    i_margin    = 16'($urandom);
    exp_ovr     = start_with_done;
    check_eq("busy_rise", 32'(o_busy), 32'd1);
    check_eq("ovr_at_start", 32'(o_overrun), 32'(exp_ovr));

    for (int k = 0; k < eff; k++) begin
      gap = $urandom_range(0, 2);
      if (start_mid && k == 1 && gap == 0) gap = 1;
      for (int g = 0; g < gap; g++) begin
        if (start_mid && k == 1) begin
          i_start    = 1'b1;
          i_num_bins = 6'd1;
        end
        i_max       = 16'($urandom);
        i_max_index = 16'($urandom);
        tick;
        i_start = 1'b0;
      end
      i_done      = 1'b1;
      i_max       = mx[k];
      i_max_index = ix[k];
      tick;
      i_done      = 1'b0;
      i_max       = 16'($urandom);
      i_max_index = 16'($urandom);
    end

    check_eq("lat_t1_valid", 32'(o_valid), 32'd0);
    check_eq("lat_t1_busy", 32'(o_busy), 32'd1);
    tick;
    check_eq("lat_t2_valid", 32'(o_valid), 32'd1);
    check_result("res", det, best, bidx, bbin, second);

    for (int h = 0; h < hold; h++) begin
      tick;
      check_eq("hold_valid", 32'(o_valid), 32'd1);
      check_eq("hold_peak", 32'(o_peak), 32'(best));
      check_eq("hold_idx", 32'(o_code_phase), 32'(bidx));
    end

    if (inj_report) begin
      i_done = 1'b1;
      i_max  = 16'hFFFF;
      tick;
      i_done  = 1'b0;
      exp_ovr = 1'b1;
      check_eq("inj_valid", 32'(o_valid), 32'd1);
      check_result("inj", det, best, bidx, bbin, second);
    end
    check_eq("ovr_report", 32'(o_overrun), 32'(exp_ovr));

    i_ready = 1'b1;
    tick;
    i_ready = 1'b0;
    check_eq("hs_valid_drop", 32'(o_valid), 32'd0);
    check_eq("hs_busy_drop", 32'(o_busy), 32'd0);
  endtask

  initial begin
    int nb, eff;

    tick;
    tick;
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_ovr", 32'(o_overrun), 32'd0);
    check_eq("rst_peak", 32'(o_peak), 32'd0);
    check_eq("rst_det", 32'(o_detected), 32'd0);
    rst = 1'b0;
    tick;

    // Stray bin result while idle.
    i_done = 1'b1;
    i_max  = 16'd500;
    tick;
    i_done = 1'b0;
    check_eq("idle_done_ovr", 32'(o_overrun), 32'd1);
    check_eq("idle_done_busy", 32'(o_busy), 32'd0);

    // Detection case, with backpressure and an injected done in REPORT.
    mx[0] = 16'd40;  ix[0] = 16'd7;
    mx[1] = 16'd300; ix[1] = 16'd1023;
    mx[2] = 16'd90;  ix[2] = 16'd5;
    mx[3] = 16'd120; ix[3] = 16'd9;
    run_sweep(4, 100, 50, 10, 1'b1, 1'b0, 1'b0);
    check_eq("d1_det", 32'(o_detected), 32'd1);
    check_eq("d1_peak", 32'(o_peak), 32'd300);
    check_eq("d1_idx", 32'(o_code_phase), 32'd1023);
    check_eq("d1_bin", 32'(o_doppler_bin), 32'd1);
    check_eq("d1_second", 32'(o_second), 32'd120);

    // Margin failure, back-to-back with the previous handshake.
    mx[3] = 16'd280;
    run_sweep(4, 100, 50, 0, 1'b0, 1'b0, 1'b0);
    check_eq("d2_det", 32'(o_detected), 32'd0);
    check_eq("d2_second", 32'(o_second), 32'd280);

    // Tie: earlier bin keeps best, equal value becomes second.
    mx[0] = 16'd200; ix[0] = 16'd3;
    mx[1] = 16'd200; ix[1] = 16'd8;
    run_sweep(2, 100, 0, 2, 1'b0, 1'b0, 1'b0);
    check_eq("tie_idx", 32'(o_code_phase), 32'd3);
    check_eq("tie_bin", 32'(o_doppler_bin), 32'd0);
    check_eq("tie_second", 32'(o_second), 32'd200);
    check_eq("tie_det", 32'(o_detected), 32'd1);

    // num_bins=0 behaves as one bin; start and done together in idle.
    mx[0] = 16'd77; ix[0] = 16'd44;
    run_sweep(0, 10, 5, 1, 1'b0, 1'b0, 1'b1);
    check_eq("nb0_peak", 32'(o_peak), 32'd77);
    check_eq("nb0_second", 32'(o_second), 32'd0);

    // i_start while collecting is ignored.
    for (int k = 0; k < 5; k++) begin mx[k] = 16'(10 * k + 1); ix[k] = 16'(k + 100); end
    run_sweep(5, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    check_eq("smid_bin", 32'(o_doppler_bin), 32'd4);

    // Reset mid-sweep.
    i_num_bins = 6'd4; i_threshold = 16'd1; i_margin = 16'd0; i_start = 1'b1;
    tick;
    i_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_done = 1'b1; i_max = 16'(1000 + k); i_max_index = 16'(k);
      tick;
    end
    i_done = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_eq("mrst_valid", 32'(o_valid), 32'd0);
    check_eq("mrst_busy", 32'(o_busy), 32'd0);
    check_eq("mrst_peak", 32'(o_peak), 32'd0);
    check_eq("mrst_idx", 32'(o_code_phase), 32'd0);
    check_eq("mrst_bin", 32'(o_doppler_bin), 32'd0);
    check_eq("mrst_second", 32'(o_second), 32'd0);
    check_eq("mrst_det", 32'(o_detected), 32'd0);
    check_eq("mrst_ovr", 32'(o_overrun), 32'd0);
    for (int k = 0; k < 6; k++) tick;
    check_eq("mrst_no_valid", 32'(o_valid), 32'd0);
    mx[0] = 16'd15; ix[0] = 16'd2;
    mx[1] = 16'd900; ix[1] = 16'd6;
    mx[2] = 16'd30; ix[2] = 16'd1;
    mx[3] = 16'd899; ix[3] = 16'd4;
    run_sweep(4, 500, 2, 0, 1'b0, 1'b0, 1'b0);

    // Randomized sweeps.
    for (int it = 0; it < 30; it++) begin
      nb  = $urandom_range(0, 9);
      eff = (nb == 0) ? 1 : nb;
      for (int k = 0; k < eff; k++) begin
        if ($urandom_range(0, 1) == 1) mx[k] = 16'($urandom_range(0, 7) * 40);
        else                           mx[k] = 16'($urandom_range(0, 65535));
        ix[k] = 16'($urandom);
      end
      run_sweep(nb,
                ($urandom_range(0, 1) == 1) ? $urandom_range(0, 400) : $urandom_range(0, 65535),
                ($urandom_range(0, 1) == 1) ? $urandom_range(0, 200) : $urandom_range(0, 65535),
                $urandom_range(0, 3),
                1'($urandom_range(0, 1)),
                (eff >= 2) ? 1'($urandom_range(0, 1)) : 1'b0,
                ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
